// File: rtl/act_pwl_pkg.sv
// Shared constants for the piecewise-linear sigmoid/tanh unit.
// Breakpoints, knots and biases are stored in Q.9 and re-aligned to the
// instance fraction width where they are used.
package act_pwl_pkg;

  localparam int NUM_SEG = 9;
  localparam int NUM_BP  = NUM_SEG - 1;
  localparam int Q_REF   = 9;

  localparam logic MODE_SIGMOID = 1'b0;
  localparam logic MODE_TANH    = 1'b1;

  // Lower bound of segments 1..8 (segment 0 is everything below the first).
  localparam int BP_Q9 [NUM_BP] = '{-2112, -1512, -1096, -560, 560, 1096, 1512, 2112};

  // Per-segment fields; segments 0 and 8 are the constant tails.
  localparam int KNOT_Q9 [NUM_SEG] = '{0, -2112, -1512, -1096, 0, 560, 1096, 1512, 0};
  localparam int BIAS_Q9 [NUM_SEG] = '{'h000, 'h008, 'h01C, 'h039, 'h100,
                                       'h183, 'h1CD, 'h1EA, 'h1FC};
  localparam int SHIFT_K [NUM_SEG] = '{0, 5, 4, 3, 2, 3, 4, 5, 0};

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/act_pwl_seg_lut.sv
// Combinational segment selector: maps the pre-scaled input u to the
// shift, knot, bias and constant-region flag of its PWL segment.
module act_pwl_seg_lut
  import act_pwl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 9
) (
  input  logic signed [WIDTH-1:0] u,
  output logic [2:0]              shift,
  output logic signed [WIDTH+1:0] knot,
  output logic signed [WIDTH+1:0] bias,
  output logic                    is_const
);

  logic [3:0]              seg;
  logic signed [WIDTH+1:0] u_ext;

  // Sign-extend a Q.9 constant and move it to the instance fraction width.
  function automatic logic signed [WIDTH+1:0] align(input int q9);
    logic signed [WIDTH+1:0] t;
    t = (WIDTH+2)'(q9);
    return t <<< (FRAC - Q_REF);
  endfunction

  assign u_ext = (WIDTH+2)'(u);

  // Segment index = number of breakpoints at or below u (lower bounds inclusive).
  always_comb begin
    // NOTE: every output gets a value before any condition so no latch is inferred.
    seg = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (u_ext >= align(BP_Q9[i])) seg = seg + 4'd1;
    end
    shift    = 3'(SHIFT_K[seg]);
    knot     = align(KNOT_Q9[seg]);
    bias     = align(BIAS_Q9[seg]);
    is_const = (seg == 4'd0) || (seg == 4'(NUM_SEG - 1));
  end

endmodule

// File: rtl/act_pwl_pipe.sv
// Three-stage pipelined PWL activation (sigmoid / tanh per sample) with
// valid/ready streaming and a pass-through tag.
// Optional build macro PWL_SAT_CNT_EN adds a 16-bit saturating counter
// (sat_cnt) of samples that land in a constant tail region.
module act_pwl_pipe
  import act_pwl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 9,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic                    in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0]        out_tag
`ifdef PWL_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam logic signed [63:0] ONE = 64'sd1 <<< FRAC;

  logic adv;

  // S1 state
  logic                    v1, m1;
  logic [TAG_W-1:0]        t1;
  logic signed [WIDTH-1:0] u1, u_pre;

  // Segment fields looked up from u1
  logic [2:0]              lut_shift;
  logic signed [WIDTH+1:0] lut_knot, lut_bias;
  logic                    lut_const;

  // S2 state
  logic                    v2, m2, c2;
  logic [TAG_W-1:0]        t2;
  logic signed [WIDTH-1:0] u2;
  logic [2:0]              sh2;
  logic signed [WIDTH+1:0] k2, b2;

  // S3 next-state
  logic signed [WIDTH+1:0] s_val;
  logic signed [WIDTH-1:0] y_next;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Pre-scale: tanh(x) = 2*sigmoid(2x) - 1, so tanh samples are doubled first.
  always_comb begin
    u_pre = in_x;
    if (in_mode != MODE_SIGMOID) u_pre = WIDTH'(sat(64'(in_x) <<< 1, WIDTH));
  end

  act_pwl_seg_lut #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lut (
    .u        (u1),
    .shift    (lut_shift),
    .knot     (lut_knot),
    .bias     (lut_bias),
    .is_const (lut_const)
  );

  // Evaluate the segment line, then post-scale tanh samples back to [-1, 1].
  always_comb begin
    s_val = b2;
    if (!c2) s_val = b2 + (((WIDTH+2)'(u2) - k2) >>> sh2);
    y_next = WIDTH'(s_val);
    if (m2 == MODE_TANH) y_next = WIDTH'(sat((64'(s_val) <<< 1) - ONE, WIDTH));
  end

  // S1 register: capture the accepted sample (in_valid only counts when adv).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      u1 <= '0;
      m1 <= 1'b0;
      t1 <= '0;
    end else if (adv) begin
      // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
      v1 <= in_valid;
      u1 <= u_pre;
      m1 <= in_mode;
      t1 <= in_tag;
    end
  end

  // S2 register: hold the selected segment alongside the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      u2  <= '0;
      m2  <= 1'b0;
      t2  <= '0;
      sh2 <= '0;
      k2  <= '0;
      b2  <= '0;
      c2  <= 1'b0;
    end else if (adv) begin
      v2  <= v1;
      u2  <= u1;
      m2  <= m1;
      t2  <= t1;
      sh2 <= lut_shift;
      k2  <= lut_knot;
      b2  <= lut_bias;
      c2  <= lut_const;
    end
  end

  // S3 register: drives the output interface directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out_y     <= y_next;
      out_tag   <= t2;
    end
  end

`ifdef PWL_SAT_CNT_EN
  // Count valid samples entering S2 in a constant tail; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (adv && v1 && lut_const && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  // Default build carries no tail counter; the constant flag only feeds S3.
`endif

endmodule

// File: tb/tb_act_pwl_pipe.sv
// Scoreboard bench for act_pwl_pipe (WIDTH=16, FRAC=9, TAG_W=4).
// Driver pushes the expected result at each handshake; a monitor pops and
// compares on every output handshake. Random samples are predicted by a
// real-valued model of the PWL segment table.
module tb_act_pwl_pipe;

  localparam int WIDTH = 16;
  localparam int FRAC  = 9;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        in_mode = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic [3:0]  out_tag;
`ifdef PWL_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  act_pwl_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
`ifdef PWL_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  tag;
    int          hs;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: segment table in real units, tanh via 2*sigmoid(2x)-1.
  function automatic logic [15:0] model(input logic [15:0] x, input logic m);
    real lo [7];
    real kn [7];
    int  bi [7];
    int  sh [7];
    int  u, s, seg;
    real ur;
    lo = '{-4.125, -2.953125, -2.140625, -1.09375, 1.09375, 2.140625, 2.953125};
    kn = '{-4.125, -2.953125, -2.140625, 0.0, 1.09375, 2.140625, 2.953125};
    bi = '{8, 28, 57, 256, 387, 461, 490};
    sh = '{5, 4, 3, 2, 3, 4, 5};
    u = int'($signed(x));
    if (m) u = clamp16(2 * u);
    ur = real'(u) / 512.0;
    if (ur < -4.125) s = 0;
    else if (ur >= 4.125) s = 508;
    else begin
      seg = 0;
      for (int i = 0; i < 7; i++) if (ur >= lo[i]) seg = i;
      s = bi[seg] + $rtoi($floor((ur - kn[seg]) * 512.0 / real'(1 << sh[seg])));
    end
    if (m) return 16'(clamp16(2 * s - 512));
    return 16'(s);
  endfunction

  function automatic bit in_tail(input logic [15:0] x, input logic m);
    int  u;
    real ur;
    u = int'($signed(x));
    if (m) u = clamp16(2 * u);
    ur = real'(u) / 512.0;
    return (ur < -4.125) || (ur >= 4.125);
  endfunction

  function automatic logic [15:0] rand_x();
    int v;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    v = int'($urandom_range(0, 5000)) - 2500;
    return 16'(v);
  endfunction

  // Output-ready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
          rdy_ph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: protocol rule, stall stability, and scoreboard comparison.
  logic        stall_q = 1'b0;
  logic [15:0] y_q = '0;
  logic [3:0]  tag_q = '0;
  exp_t        got;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (stall_q) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_y", 32'(out_y), 32'(y_q));
          check("stall_tag", 32'(out_tag), 32'(tag_q));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got y=0x%0h tag=0x%0h, expected no output (cycle %0d)",
                     out_y, out_tag, cyc);
          end else begin
            got = sb.pop_front();
            check("y", 32'(out_y), 32'(got.y));
            check("tag", 32'(out_tag), 32'(got.tag));
            if (got.lat) check("latency", 32'(cyc - got.hs), 3);
          end
        end
        stall_q = out_valid && !out_ready;
        y_q     = out_y;
        tag_q   = out_tag;
      end
    end
  end

  // Present one sample until accepted; expected result queued at the handshake.
  task automatic send(input logic [15:0] x, input logic m, input logic [3:0] t,
                      input logic [15:0] y, input bit lat);
    exp_t e;
    in_valid = 1'b1;
    in_x     = x;
    in_mode  = m;
    in_tag   = t;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = y;
        e.tag = t;
        e.hs = cyc;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [15:0] x, input logic m, input logic [3:0] t);
    send(x, m, t, model(x, m), 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    logic [15:0] x;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_y", 32'(out_y), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Zero input, extremes, segment boundaries (latency checked on each)
    send(16'h0000, 1'b0, 4'hA, 16'h0100, 1'b1);
    send(16'h0000, 1'b1, 4'h5, 16'h0000, 1'b1);
    send(16'h7FFF, 1'b0, 4'h1, 16'h01FC, 1'b1);
    send(16'h8000, 1'b0, 4'h2, 16'h0000, 1'b1);
    send(16'h8000, 1'b1, 4'h3, 16'hFE00, 1'b1);
    send(16'h7FFF, 1'b1, 4'h4, 16'h01F8, 1'b1);
    send(16'h0230, 1'b0, 4'h6, 16'h0183, 1'b1);
    send(16'h022F, 1'b0, 4'h7, 16'h018B, 1'b1);
    send(16'hF7C0, 1'b0, 4'h8, 16'h0008, 1'b1);
    send(16'hF7BF, 1'b0, 4'h9, 16'h0000, 1'b1);
    drain();

    // Backpressure: 8 back-to-back, alternating modes, ready 1,0,0,1
    rdy_ph = 0;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand(rand_x(), 1'(i % 2), 4'($urandom));
    drain();
    rdy_mode = 0;
    idle(2);

    // Reset with three samples in flight
    send_rand(16'h0100, 1'b0, 4'hB);
    send_rand(16'hFE00, 1'b1, 4'hC);
    send_rand(16'h0400, 1'b0, 4'hD);
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 1);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_y", 32'(out_y), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle_valid", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(16'h0230, 1'b0, 4'hE, 16'h0183, 1'b1);
    drain();

    // Random traffic with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_rand(rand_x(), 1'($urandom_range(0, 1)), 4'($urandom));
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    rdy_mode = 0;
    idle(2);

`ifdef PWL_SAT_CNT_EN
    // Tail counter from a clean reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("sat_cnt_rst", 32'(sat_cnt), 0);
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: x = 16'h7000;
        1: x = 16'h9000;
        2: x = 16'h0000;
        3: x = 16'h0900;
        default: x = 16'hF7C0;
      endcase
      if (in_tail(x, 1'b0)) exp_cnt++;
      send_rand(x, 1'b0, 4'(i));
    end
    drain();
    idle(2);
    check("sat_cnt", 32'(sat_cnt), 32'(exp_cnt));
`else
    exp_cnt = 0;
    x = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_pwl_pipe.md
Name: act_pwl_pipe

Overview:
Pipelined, parametrised piecewise-linear activation unit. Successor to the combinational 16-bit sigmoid PWL: generic width and fraction, per-sample sigmoid/tanh mode, valid/ready streaming with a pass-through tag. Sits between the MAC/accumulator output stage and the next layer's input buffer. Throughput is one sample per clock.

Parameters:
WIDTH, 16, signed two's-complement data width of x and y (>= 12)
FRAC, 9, fractional bits of x and y; legal range 9..WIDTH-4
TAG_W, 4, width of the sideband tag carried alongside each sample

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  unit can accept an input this cycle
in_x  in  WIDTH  input, signed QX.FRAC
in_mode  in  1  0 = sigmoid, 1 = tanh
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_y  out  WIDTH  result, signed QX.FRAC
out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset is asynchronous and active-high. All stage valids are 0, and out_valid, out_y and out_tag are 0. in_ready is 1 one cycle after reset deasserts.
- Pipeline is three register stages: S1 pre-scale, S2 segment select, S3 evaluate/post-scale (the S3 register drives out_*). Latency from input handshake to out_valid is 3 cycles.
- Global advance: adv = !out_valid | out_ready. in_ready = adv. When adv is 0, every stage holds. Bubbles are not compressed.
- Input is accepted on in_valid & in_ready. Output is consumed on out_valid & out_ready.
- S1: if mode = 1, u = sat(x << 1); otherwise u = x. sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- S2: compares u (signed) against 8 breakpoints and registers shift_k, knot_k, bias_k and the zero/const flags.
- Breakpoints, knots and biases are given in Q.9 and aligned by << (FRAC-9).
- Segment table, with x in real units, bias in Q.9 hex:
  - u < -4.125: y = 0x000 (constant)
  - [-4.125, -2.953125): knot -4.125, bias 0x008, shift 5
  - [-2.953125, -2.140625): knot -2.953125, bias 0x01C, shift 4
  - [-2.140625, -1.09375): knot -2.140625, bias 0x039, shift 3
  - [-1.09375, 1.09375): knot 0, bias 0x100, shift 2
  - [1.09375, 2.140625): knot 1.09375, bias 0x183, shift 3
  - [2.140625, 2.953125): knot 2.140625, bias 0x1CD, shift 4
  - [2.953125, 4.125): knot 2.953125, bias 0x1EA, shift 5
  - u >= 4.125: y = 0x1FC (constant)
- Each lower bound is inclusive.
- S3: s = bias + ((u - knot) >>> shift). The subtraction and add are done at WIDTH+2 bits with an arithmetic shift, so s is never negative and never above ONE.
- Post-scale: mode 0 gives y = s; mode 1 gives y = sat((s << 1) - ONE), where ONE = 1 << FRAC.
- Mode and tag travel with their sample through every stage.
- Reset mid-stream: all in-flight samples are discarded and no partial result is output.

Optional Feature:
PWL_SAT_CNT_EN
- Defined: adds output port sat_cnt, 16 bits. It counts accepted samples that land in either constant region, evaluated at S2 advance. It saturates at 0xFFFF and clears on rst.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package act_pwl_pkg holds the Q.9 breakpoint, knot, bias and shift constant arrays, the segment-count constant (9), the mode encoding constants, and the sat() function.
- One sub-module, act_pwl_seg_lut: purely combinational, maps u to the segment fields, and is registered by S2.

Test Plan:
All values are for WIDTH=16, FRAC=9.
1. Zero input: sigmoid x=0x0000 gives 0x0100; tanh x=0x0000 gives 0x0000. out_valid rises exactly 3 cycles after the handshake, and the tag is preserved.
2. Extremes: sigmoid x=0x7FFF gives 0x01FC and x=0x8000 gives 0x0000; tanh x=0x8000 gives 0xFE00 and x=0x7FFF gives 0x01F8.
3. Boundaries: sigmoid x=0x0230 gives 0x0183; x=0x022F gives 0x018B; x=0xF7C0 gives 0x0008; x=0xF7BF gives 0x0000.
4. Backpressure: stream 8 back-to-back samples with alternating modes and random tags while out_ready toggles 1,0,0,1. Results arrive in order with no loss or duplication, out_* are stable while stalled, and in_ready equals !out_valid | out_ready.
5. Reset mid-stream: assert rst with 3 samples in flight. out_valid drops immediately (asynchronously) and stays 0; the first post-reset input gives a correct result 3 cycles after its handshake.
6. With PWL_SAT_CNT_EN defined: send 5 inputs, 0x7000, 0x9000, 0x0000, 0x0900 and 0xF7C0. sat_cnt ends at 3.
